// File: rtl/interface_rr_arbiter.sv
// Packet-locked weighted round-robin arbiter. Grants are registered and held
// until the packet's last beat is accepted or the owner drops its request.
// Each grant covers up to weight packets before the rotating pointer moves on.
module interface_rr_arbiter #(
  parameter int unsigned IN_COUNT = 4,
  parameter int unsigned WEIGHT_W = 4,
  localparam int unsigned SEL_W = $clog2(IN_COUNT)
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [IN_COUNT-1:0]          req_i,
  input  logic                         last_i,
  input  logic                         ready_i,
  input  logic [IN_COUNT*WEIGHT_W-1:0] weight_i,
  output logic [IN_COUNT-1:0]          gnt_o,
  output logic [SEL_W-1:0]             sel_o,
  output logic                         gnt_valid_o,
  output logic [WEIGHT_W-1:0]          credit_o
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [IN_COUNT-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic                win_found;
  logic [SEL_W-1:0]    win_idx;
  logic [WEIGHT_W-1:0] win_weight;
  logic [WEIGHT_W-1:0] win_credit;
  int unsigned         cand;

  logic req_sel, pkt_last, abort;

  // Winner search: first requester after the last-served pointer, wrapping.
  // ptr_q always equals sel_q while granted, so one search covers idle and rotate.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned d = 1; d <= IN_COUNT; d++) begin
      cand = (32'(ptr_q) + d) % IN_COUNT;
      if (!win_found && req_i[SEL_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = SEL_W'(cand);
      end
    end
  end

  // Weight of the search winner; a zero weight still grants one packet.
  always_comb begin
    win_weight = '0;
    for (int unsigned k = 0; k < IN_COUNT; k++) begin
      if (SEL_W'(k) == win_idx) win_weight = weight_i[k*WEIGHT_W +: WEIGHT_W];
    end
    win_credit = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
  end

  assign req_sel  = req_i[sel_q];
  assign pkt_last = (state_q == StGrant) && ready_i && req_sel && last_i;
  assign abort    = (state_q == StGrant) && !req_sel;

  // Next-state: issue, hold, consume credit, hand over or release.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    if ((state_q == StIdle) || abort || pkt_last) begin
      if (pkt_last && (credit_q > WEIGHT_W'(1))) begin
        // Owner still requesting (beat was accepted): keep the grant.
        credit_d = credit_q - WEIGHT_W'(1);
      end else if (win_found) begin
        state_d  = StGrant;
        gnt_d    = IN_COUNT'(1) << win_idx;
        sel_d    = win_idx;
        ptr_d    = win_idx;
        credit_d = win_credit;
      end else begin
        state_d  = StIdle;
        gnt_d    = '0;
        credit_d = '0;
      end
    end
  end

  // State registers; reset drops any grant immediately.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      sel_q    <= '0;
      ptr_q    <= SEL_W'(IN_COUNT - 1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign sel_o       = sel_q;
  assign gnt_valid_o = (state_q == StGrant);
  assign credit_o    = credit_q;

endmodule
